// File: rtl/ema_filter_mc_if.sv
`default_nettype none
// ============================================================================
// ema_filter_mc_if : sample, coefficient-config and result bundle for ema_filter_mc
// Rev 1.0
// ============================================================================
interface ema_filter_mc_if #(
  parameter int NCH      = 4,
  parameter int DWIDTH   = 27,
  parameter int BWIDTH   = 18,
  parameter int OUTWIDTH = 48,
  parameter int CHW      = (NCH > 1) ? $clog2(NCH) : 1
);
  logic                       in_valid;
  logic [CHW-1:0]             in_ch;
  logic [DWIDTH-1:0]          in_data;
  logic                       cfg_we;
  logic [CHW-1:0]             cfg_ch;
  logic [BWIDTH-1:0]          cfg_coeff;
  logic                       ch_clr;
  logic                       out_valid;
  logic [CHW-1:0]             out_ch;
  logic signed [OUTWIDTH-1:0] out_data;
  logic                       out_sat;

  modport master (
    output in_valid, in_ch, in_data, cfg_we, cfg_ch, cfg_coeff, ch_clr,
    input  out_valid, out_ch, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_ch, in_data, cfg_we, cfg_ch, cfg_coeff, ch_clr,
    output out_valid, out_ch, out_data, out_sat
  );
endinterface
`default_nettype wire

// File: rtl/ema_filter_mc.sv
`default_nettype none
// ============================================================================
// ema_filter_mc : time-multiplexed per-channel EMA filter, 3-stage pipeline.
// Optional macro EMA_ROUND_EN: round-half-up instead of floor in the diff path.
// Rev 1.0
// ============================================================================
module ema_filter_mc #(
  parameter int NCH      = 4,
  parameter int DWIDTH   = 27,
  parameter int BWIDTH   = 18,
  parameter int FRAC     = 14,
  parameter int OUTWIDTH = 48
) (
  input wire             clk,
  input wire             rst,
  ema_filter_mc_if.slave bus
);
  localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1;
  // diff is wide enough to hold any scaled accumulator, so an unstable
  // coefficient diverges into saturation instead of wrapping; for stable
  // coefficients its value always fits DWIDTH+1 bits.
  localparam int DIFFW = OUTWIDTH - FRAC + 2;
  localparam int PRODW = BWIDTH + 1 + DIFFW;
  localparam int SUMW  = PRODW + 1;

  localparam logic signed [OUTWIDTH-1:0] ACC_MAX = {1'b0, {(OUTWIDTH-1){1'b1}}};
  localparam logic signed [OUTWIDTH-1:0] ACC_MIN = {1'b1, {(OUTWIDTH-1){1'b0}}};
`ifdef EMA_ROUND_EN
  localparam logic [OUTWIDTH:0] RND_BIAS = (OUTWIDTH+1)'(1) << (FRAC - 1);
`else
  localparam logic [OUTWIDTH:0] RND_BIAS = '0;
`endif

  logic signed [OUTWIDTH-1:0] acc_mem   [NCH];
  logic [BWIDTH-1:0]          coeff_mem [NCH];

  logic                       s1_valid;
  logic [CHW-1:0]             s1_ch;
  logic [DWIDTH-1:0]          s1_data;
  logic [BWIDTH-1:0]          s1_coeff;

  logic                       s2_valid;
  logic [CHW-1:0]             s2_ch;
  logic [BWIDTH-1:0]          s2_coeff;
  logic signed [OUTWIDTH-1:0] s2_acc;
  logic signed [DIFFW-1:0]    s2_diff;

  logic                       out_valid_q;
  logic [CHW-1:0]             out_ch_q;
  logic signed [OUTWIDTH-1:0] out_data_q;
  logic                       out_sat_q;

  logic signed [OUTWIDTH-1:0] acc_rd;
  logic [OUTWIDTH:0]          acc_bias;
  logic signed [DIFFW-2:0]    acc_scaled;
  logic signed [DIFFW-1:0]    diff;
  logic signed [PRODW-1:0]    prod;
  logic signed [SUMW-1:0]     sum;
  logic signed [OUTWIDTH-1:0] res;
  logic                       res_sat;
  logic                       unused_frac_bits;

  // S1: register the sample and latch its coefficient before any same-cycle write
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_ch    <= '0;
      s1_data  <= '0;
      s1_coeff <= '0;
    end else begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_ch    <= bus.in_ch;
        s1_data  <= bus.in_data;
        s1_coeff <= coeff_mem[bus.in_ch];
      end
    end
  end

  // S2 read: forward the result being written this cycle; a clear wins over both
  always_comb begin
    acc_rd = acc_mem[s1_ch];
    if (s2_valid && (s2_ch == s1_ch)) begin
      acc_rd = res;
    end
    if (bus.ch_clr && (bus.cfg_ch == s1_ch)) begin
      acc_rd = '0;
    end
  end

  always_comb begin
    acc_bias   = {acc_rd[OUTWIDTH-1], acc_rd} + RND_BIAS;
    acc_scaled = acc_bias[OUTWIDTH:FRAC];
    diff       = DIFFW'($signed({1'b0, s1_data})) - DIFFW'(acc_scaled);
  end

  assign unused_frac_bits = ^acc_bias[FRAC-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_ch    <= '0;
      s2_coeff <= '0;
      s2_acc   <= '0;
      s2_diff  <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_ch    <= s1_ch;
        s2_coeff <= s1_coeff;
        s2_acc   <= acc_rd;
        s2_diff  <= diff;
      end
    end
  end

  // S3: full-precision multiply-add, then clamp to the accumulator range
  always_comb begin
    prod    = PRODW'($signed({1'b0, s2_coeff})) * PRODW'(s2_diff);
    sum     = SUMW'(s2_acc) + SUMW'(prod);
    res_sat = 1'b0;
    res     = sum[OUTWIDTH-1:0];
    if (sum[SUMW-1:OUTWIDTH-1] != {(SUMW-OUTWIDTH+1){sum[SUMW-1]}}) begin
      res_sat = 1'b1;
      res     = sum[SUMW-1] ? ACC_MIN : ACC_MAX;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        acc_mem[i]   <= '0;
        coeff_mem[i] <= '0;
      end
    end else begin
      if (bus.cfg_we) begin
        coeff_mem[bus.cfg_ch] <= bus.cfg_coeff;
      end
      if (s2_valid) begin
        acc_mem[s2_ch] <= res;
      end
      // Placed last so a same-cycle clear overrides the writeback
      if (bus.ch_clr) begin
        acc_mem[bus.cfg_ch] <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      out_valid_q <= s2_valid;
      if (s2_valid) begin
        out_ch_q   <= s2_ch;
        out_data_q <= res;
        out_sat_q  <= res_sat;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sat   = out_sat_q;
endmodule
`default_nettype wire
